tlp_tx_arbiter: RTL and testbench
=================================

# tlp_tx_arbiter

Packet-level round-robin arbiter that shares the single FPGA->Host TLP pipe (64-bit data, SOP/EOP, valid/ready) between NUM_REQ requesters, e.g. the register-read completer and a DMA write engine. It sits between the application-side TLP sources and the `txData_in`/`txSOP_in`/`txEOP_in`/`txValid_in`/`txReady_out` inputs of the PCIe core wrapper. Once a TLP starts, it is never interleaved with another.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.

Ports:
- pcieClk_in  in  1  PCIe core clock; the only clock.
- pcieRst_in  in  1  synchronous, active-high reset.
- reqData_in  in  NUM_REQ x 64 (`tlp_xcvr_pkg::uint64`)  per-requester TLP beat.
- reqSOP_in  in  NUM_REQ  first beat of a TLP.
- reqEOP_in  in  NUM_REQ  last beat of a TLP.
- reqValid_in  in  NUM_REQ  beat valid.
- reqReady_out  out  NUM_REQ  beat accepted when valid and ready are both high.
- txData_out  out  64  to core TX pipe.
- txSOP_out, txEOP_out, txValid_out  out  1 each  to core TX pipe.
- txReady_in  in  1  core TX pipe ready.
- grant_out  out  NUM_REQ  one-hot current owner; zero when idle with no request.
- busy_out  out  1  high while a multi-beat TLP is mid-transfer.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: combinational round-robin pick among requesters with reqValid_in high. Search starts at index `last+1` and wraps modulo NUM_REQ; `last` resets to NUM_REQ-1, so requester 0 wins first.
- The granted requester's data, SOP, EOP and valid pass straight to tx*_out. `reqReady_out[g] = txReady_in`; all other ready bits are 0.
- Beat transfer = txValid_out & txReady_in.
- IDLE, transfer with EOP=1 (single-beat TLP): stay IDLE and set `last <= g`.
- IDLE, transfer with EOP=0: go to BUSY and register `owner <= g`.
- IDLE, no transfer (txReady_in low): nothing is registered. The pick is re-evaluated next cycle. A requester that has asserted valid holds it, so it only loses to a new, higher-rotation arrival. This is legal because no beat has moved.
- BUSY: grant is fixed to `owner`, regardless of other requests. On a transfer with EOP=1: `last <= owner`, go to IDLE.
- BUSY, owner valid low: a bubble. txValid_out is 0 and the grant is held.
- Protocol rules required of requesters: the first valid beat of a TLP carries SOP=1. In IDLE the arbiter does not check SOP. A granted IDLE beat is treated as a start.
- grant_out is the current combinational grant, one-hot.

## Timing
- Zero-cycle data latency: tx*_out is combinational from req*_in and registered state. Ready is combinational from txReady_in.
- Back-to-back TLPs from different requesters are allowed with no dead cycle: EOP of A in cycle n, SOP of B in cycle n+1.
- The same requester can be re-granted next cycle only if no other requester is valid.
- Reset values: state=IDLE, last=NUM_REQ-1, owner=0, busy_out=0. After reset, tx*_out are driven by the IDLE pick, so they are 0 when no requester is valid.
- Reset mid-TLP abandons the packet. The owner must also be reset, because the core wrapper shares pcieRst_in.

## Configuration
- `TLP_TX_ARB_STATS_EN` defined:
  - Adds output `pktCount_out` (NUM_REQ x 32), one counter per requester.
  - A counter increments on each EOP transfer from that requester and wraps from 0xFFFFFFFF to 0.
  - Counters reset to 0.
- Undefined: the port and counters are absent. Behaviour is otherwise identical.

## Structure
- `tlp_xcvr_pkg` holds `uint64`, a new `ArbState` enum {IDLE, BUSY} and `MAX_REQ = 4`.
- One sub-module, `rr_pick`: a combinational round-robin priority encoder (inputs: request vector and last index; outputs: one-hot grant and index). It is reusable by the RX-side steering logic.

## Test plan
- Reset, then requester 0 sends a 3-beat TLP (0x11, 0x22, 0x33) with txReady_in=1 -> tx sees the beats in 3 consecutive cycles, SOP on 0x11, EOP on 0x33; busy_out=1 for cycles 2-3.
- Both requesters valid with 2-beat TLPs -> order is req0, req1, req0, req1. No interleaving and no idle cycle between packets.
- Req1 mid-TLP (BUSY) while req0 raises valid -> req0 stays unready until req1's EOP transfers, then is granted the next cycle.
- txReady_in held low 4 cycles mid-packet -> data is stable, no beat lost or duplicated, owner unchanged.
- Single-beat TLPs (SOP=EOP=1) from 3 requesters (NUM_REQ=3) continuously valid -> grants rotate 0,1,2,0 every cycle.
- With `TLP_TX_ARB_STATS_EN`: 5 TLPs from req0 and 2 from req1 -> pktCount_out = {2,5}. Assert reset mid-packet -> counters are 0 and state is IDLE on the next cycle.

Source files
------------

// File: rtl/tlp_xcvr_pkg.sv
// rtl/tlp_xcvr_pkg.sv - shared types and constants for the TLP transmit/receive path
package tlp_xcvr_pkg;

    typedef logic [63:0] uint64;

    localparam int MAX_REQ = 4;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ArbState;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder (search starts after last)
module rr_pick
    import tlp_xcvr_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_lo_idx;
    logic             w_lo_any;
    logic [IDX_W-1:0] w_hi_idx;
    logic             w_hi_any;

    // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        w_lo_idx = '0;
        w_lo_any = 1'b0;
        w_hi_idx = '0;
        w_hi_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_idx = IDX_W'(i);
                w_lo_any = 1'b1;
            end
            if (i_req[i] && (i > int'(i_last))) begin
                w_hi_idx = IDX_W'(i);
                w_hi_any = 1'b1;
            end
        end
    end

    assign o_any   = w_lo_any;
    assign o_idx   = w_hi_any ? w_hi_idx : w_lo_idx;
    assign o_grant = w_lo_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/tlp_tx_arbiter.sv
// rtl/tlp_tx_arbiter.sv - packet-level round-robin TX TLP arbiter; optional counters via TLP_TX_ARB_STATS_EN
module tlp_tx_arbiter
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                    pcieClk_in,
    input  logic                    pcieRst_in,
    input  logic [NUM_REQ*64-1:0]   reqData_in,
    input  logic [NUM_REQ-1:0]      reqSOP_in,
    input  logic [NUM_REQ-1:0]      reqEOP_in,
    input  logic [NUM_REQ-1:0]      reqValid_in,
    output logic [NUM_REQ-1:0]      reqReady_out,
    output logic [63:0]             txData_out,
    output logic                    txSOP_out,
    output logic                    txEOP_out,
    output logic                    txValid_out,
    input  logic                    txReady_in,
    output logic [NUM_REQ-1:0]      grant_out,
    output logic                    busy_out
`ifdef TLP_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]   pktCount_out
`endif
);

    ArbState          r_state;
    ArbState          w_state_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_xfer;

    rr_pick #(
        .N(NUM_REQ)
    ) u_rr_pick (
        .i_req   (reqValid_in),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // While a TLP is in flight the owner keeps the pipe; otherwise the live pick does.
    always_comb begin
        if (r_state == BUSY) begin
            w_sel_idx = r_owner;
            w_grant   = NUM_REQ'(1) << r_owner;
        end else begin
            w_sel_idx = w_pick_idx;
            w_grant   = w_pick_any ? w_pick_grant : '0;
        end
    end

    // Route the granted requester's beat straight through to the core pipe.
    always_comb begin
        txData_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                txData_out = reqData_in[i*64 +: 64];
            end
        end
    end

    assign txValid_out  = |(w_grant & reqValid_in);
    assign txSOP_out    = |(w_grant & reqSOP_in);
    assign txEOP_out    = |(w_grant & reqEOP_in);
    assign reqReady_out = txReady_in ? w_grant : '0;
    assign grant_out    = w_grant;
    assign busy_out     = (r_state == BUSY);
    assign w_xfer       = txValid_out & txReady_in;

    // Next state: a non-EOP beat locks the owner, an EOP beat rotates the priority.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (txEOP_out) begin
                        w_last_nxt = w_sel_idx;
                    end else begin
                        w_state_nxt = BUSY;
                        w_owner_nxt = w_sel_idx;
                    end
                end
            end
            BUSY: begin
                if (w_xfer && txEOP_out) begin
                    w_last_nxt  = r_owner;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Arbitration state; reset abandons any packet in flight so requester 0 goes first.
    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            r_state <= IDLE;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
        end
    end

`ifdef TLP_TX_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] r_pkt_count;

    // Per-requester completed-TLP counters, wrapping naturally at 2^32.
    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            r_pkt_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_xfer && txEOP_out && w_grant[i]) begin
                    r_pkt_count[i*32 +: 32] <= r_pkt_count[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign pktCount_out = r_pkt_count;
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb/tb_tlp_tx_arbiter.sv - self-checking bench for tlp_tx_arbiter
module tb_tlp_tx_arbiter;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*64-1:0]  req_data;
    logic [N-1:0]     req_sop;
    logic [N-1:0]     req_eop;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [63:0]      tx_data;
    logic             tx_sop;
    logic             tx_eop;
    logic             tx_valid;
    logic             tx_ready;
    logic [N-1:0]     grant;
    logic             busy;
`ifdef TLP_TX_ARB_STATS_EN
    logic [N*32-1:0]  pkt_count;
`endif

    always #5 clk = ~clk;

    tlp_tx_arbiter #(.NUM_REQ(N)) dut (
        .pcieClk_in   (clk),
        .pcieRst_in   (rst),
        .reqData_in   (req_data),
        .reqSOP_in    (req_sop),
        .reqEOP_in    (req_eop),
        .reqValid_in  (req_valid),
        .reqReady_out (req_ready),
        .txData_out   (tx_data),
        .txSOP_out    (tx_sop),
        .txEOP_out    (tx_eop),
        .txValid_out  (tx_valid),
        .txReady_in   (tx_ready),
        .grant_out    (grant),
        .busy_out     (busy)
`ifdef TLP_TX_ARB_STATS_EN
        ,
        .pktCount_out (pkt_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Per-requester source queues: bit 66 bubble, 65 SOP, 64 EOP, 63:0 data.
    logic [66:0] q[N][$];

    // Model of the arbitration rules: who owns the pipe, who went last, how many TLPs done.
    bit          m_busy  = 0;
    int          m_owner = 0;
    int          m_last  = N - 1;
    logic [31:0] m_cnt[N];
    int          cyc = 0;
    bit          chk_en = 0;

    int          lg_req[$];
    logic [63:0] lg_data[$];
    int          lg_cyc[$];

    function automatic int exp_grant();
        if (m_busy) return m_owner;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Requester sources: present the front of each queue just after the clock edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && !q[i][0][66]) begin
                req_valid[i]         = 1'b1;
                req_sop[i]           = q[i][0][65];
                req_eop[i]           = q[i][0][64];
                req_data[i*64 +: 64] = q[i][0][63:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_sop[i]           = 1'b0;
                req_eop[i]           = 1'b0;
                req_data[i*64 +: 64] = '0;
            end
        end
    end

    // Model update at the clock edge: consume transferred beats and bubbles.
    always @(posedge clk) begin
        bit bub[N];
        int g;
        logic [66:0] e;
        cyc++;
        if (rst) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = N - 1;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                q[i].delete();
            end
        end else begin
            for (int i = 0; i < N; i++) bub[i] = (q[i].size() > 0) && q[i][0][66];
            g = exp_grant();
            if (g >= 0 && req_valid[g] && tx_ready) begin
                e = q[g].pop_front();
                lg_req.push_back(g);
                lg_data.push_back(e[63:0]);
                lg_cyc.push_back(cyc);
                if (e[64]) begin
                    m_busy   = 0;
                    m_last   = g;
                    m_cnt[g] = m_cnt[g] + 1;
                end else begin
                    m_busy  = 1;
                    m_owner = g;
                end
            end
            for (int i = 0; i < N; i++) if (bub[i]) void'(q[i].pop_front());
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] eg;
        if (chk_en && !rst) begin
            g  = exp_grant();
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            chk("grant", grant, eg);
            chk("ready", req_ready, tx_ready ? eg : '0);
            chk("busy", busy, m_busy);
            if (g >= 0 && req_valid[g]) begin
                chk("tx_valid", tx_valid, 1);
                chk("tx_data", tx_data, q[g][0][63:0]);
                chk("tx_sop", tx_sop, q[g][0][65]);
                chk("tx_eop", tx_eop, q[g][0][64]);
            end else begin
                chk("tx_valid", tx_valid, 0);
                if (g < 0) chk("tx_data_idle", tx_data, 0);
            end
`ifdef TLP_TX_ARB_STATS_EN
            for (int i = 0; i < N; i++) chk("pkt_count", pkt_count[i*32 +: 32], m_cnt[i]);
`endif
        end
    end

    task automatic push_pkt(input int r, input logic [63:0] base, input int n);
        for (int b = 0; b < n; b++) q[r].push_back({1'b0, (b == 0), (b == n - 1), base + 64'(b)});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        lg_req.delete();
        lg_data.delete();
        lg_cyc.delete();
    endtask

    task automatic run_all(input string name);
        int k;
        int left;
        k = 0;
        left = q[0].size() + q[1].size() + q[2].size();
        while (left != 0 && k < 200) begin
            @(posedge clk);
            #2;
            k++;
            left = q[0].size() + q[1].size() + q[2].size();
        end
        chk({name, "_drain"}, left, 0);
    endtask

    task automatic chk_log(input string name, input logic [63:0] exp[$]);
        chk({name, "_len"}, lg_data.size(), exp.size());
        for (int i = 0; i < exp.size() && i < lg_data.size(); i++) chk({name, "_beat"}, lg_data[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [63:0] ex[$];
        logic [63:0] sd[3];
        logic        sb[3];
        logic        ss[3];
        logic        se[3];

        rst       = 1'b1;
        tx_ready  = 1'b1;
        req_data  = '0;
        req_sop   = '0;
        req_eop   = '0;
        req_valid = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        do_reset();
        chk_en = 1;

        // Reset state with no requests.
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_ready", req_ready, 0);

        // Three-beat TLP from req0.
        do_reset();
        push_pkt(0, 64'h11, 1);
        push_pkt(0, 64'h22, 1);
        push_pkt(0, 64'h33, 1);
        q[0][0][64] = 1'b0;
        q[0][1][65] = 1'b0;
        q[0][1][64] = 1'b0;
        q[0][2][65] = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sd[k] = tx_data;
            sb[k] = busy;
            ss[k] = tx_sop;
            se[k] = tx_eop;
        end
        chk("t1_d0", sd[0], 64'h11);
        chk("t1_d1", sd[1], 64'h22);
        chk("t1_d2", sd[2], 64'h33);
        chk("t1_busy0", sb[0], 0);
        chk("t1_busy1", sb[1], 1);
        chk("t1_busy2", sb[2], 1);
        chk("t1_sop0", ss[0], 1);
        chk("t1_sop2", ss[2], 0);
        chk("t1_eop1", se[1], 0);
        chk("t1_eop2", se[2], 1);
        run_all("t1");

        // Two requesters, two 2-beat TLPs each: alternate with no gap.
        do_reset();
        push_pkt(0, 64'hA0, 2);
        push_pkt(1, 64'hB0, 2);
        push_pkt(0, 64'hC0, 2);
        push_pkt(1, 64'hD0, 2);
        run_all("t2");
        ex = '{64'hA0, 64'hA1, 64'hB0, 64'hB1, 64'hC0, 64'hC1, 64'hD0, 64'hD1};
        chk_log("t2", ex);
        if (lg_cyc.size() == 8) chk("t2_span", lg_cyc[7] - lg_cyc[0], 7);

        // Req1 owns the pipe when req0 arrives: req0 waits for req1's EOP.
        do_reset();
        push_pkt(1, 64'h31, 3);
        @(posedge clk);
        @(posedge clk);
        #2;
        push_pkt(0, 64'h01, 2);
        run_all("t3");
        ex = '{64'h31, 64'h32, 64'h33, 64'h01, 64'h02};
        chk_log("t3", ex);
        if (lg_req.size() == 5) begin
            chk("t3_req3", lg_req[3], 0);
            chk("t3_span", lg_cyc[4] - lg_cyc[0], 4);
        end

        // Core stalls four cycles mid-packet while another requester waits.
        do_reset();
        push_pkt(0, 64'h41, 4);
        push_pkt(1, 64'h51, 1);
        @(posedge clk);
        @(posedge clk);
        #2 tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_hold_data", tx_data, 64'h42);
            chk("t4_hold_grant", grant, 3'b001);
        end
        @(posedge clk);
        #2 tx_ready = 1'b1;
        run_all("t4");
        ex = '{64'h41, 64'h42, 64'h43, 64'h44, 64'h51};
        chk_log("t4", ex);

        // Single-beat TLPs from all three requesters rotate every cycle.
        do_reset();
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < N; r++) push_pkt(r, 64'h100 + 64'(16 * rep + r), 1);
        run_all("t5");
        chk("t5_len", lg_req.size(), 6);
        if (lg_req.size() == 6) begin
            chk("t5_r0", lg_req[0], 0);
            chk("t5_r1", lg_req[1], 1);
            chk("t5_r2", lg_req[2], 2);
            chk("t5_r3", lg_req[3], 0);
            chk("t5_span", lg_cyc[5] - lg_cyc[0], 5);
        end

        // Owner bubble mid-packet: grant held, other requester still waits.
        do_reset();
        q[0].push_back({1'b0, 1'b1, 1'b0, 64'h61});
        q[0].push_back({1'b1, 1'b0, 1'b0, 64'h0});
        q[0].push_back({1'b0, 1'b0, 1'b1, 64'h62});
        push_pkt(1, 64'h71, 1);
        run_all("t6");
        ex = '{64'h61, 64'h62, 64'h71};
        chk_log("t6", ex);

`ifdef TLP_TX_ARB_STATS_EN
        // Packet counters: five TLPs from req0, two from req1.
        do_reset();
        for (int k = 0; k < 5; k++) push_pkt(0, 64'h80 + 64'(k), 1);
        push_pkt(1, 64'h90, 2);
        push_pkt(1, 64'h98, 2);
        run_all("t7");
        @(negedge clk);
        chk("t7_cnt0", pkt_count[31:0], 5);
        chk("t7_cnt1", pkt_count[63:32], 2);
        chk("t7_cnt2", pkt_count[95:64], 0);
`endif

        // Reset in the middle of a packet abandons it.
        push_pkt(0, 64'hE0, 3);
        @(posedge clk);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("t8_busy_mid", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t8_busy", busy, 0);
        chk("t8_grant", grant, 0);
        chk("t8_valid", tx_valid, 0);
`ifdef TLP_TX_ARB_STATS_EN
        chk("t8_cnt0", pkt_count[31:0], 0);
        chk("t8_cnt1", pkt_count[63:32], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
